// File: rtl/riscv_defs_pkg.sv
// Shared RV32I definitions: opcodes, ALU operation codes, decoder control bundle
// and the combinational ALU function used by the execute stage.
package riscv_defs;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_SUM   = 4'b0010,
    ALU_EQUAL = 4'b0011,
    ALU_SLL   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SRA   = 4'b0111,
    ALU_XOR   = 4'b1000,
    ALU_NOR   = 4'b1001,
    ALU_SUB   = 4'b1010,
    ALU_GE    = 4'b1100,
    ALU_GEU   = 4'b1101,
    ALU_SLT   = 4'b1110,
    ALU_SLTU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;

  typedef struct packed {
    alu_op_e alu_op;
    a_sel_e  a_sel;
    logic    b_imm;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    is_branch;
    logic    is_jal;
    logic    is_jalr;
    logic    illegal;
  } ctrl_t;

  // Comparison ops return 0/1 in bit 0 so branch resolution can read result[0].
  function automatic logic [31:0] alu_compute(input alu_op_e op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_SUM:   r = a + b;
      ALU_EQUAL: r = {31'b0, a == b};
      ALU_SLL:   r = a << b[4:0];
      ALU_SRL:   r = a >> b[4:0];
      ALU_SRA:   r = $signed(a) >>> b[4:0];
      ALU_XOR:   r = a ^ b;
      ALU_NOR:   r = ~(a | b);
      ALU_SUB:   r = a - b;
      ALU_GE:    r = {31'b0, $signed(a) >= $signed(b)};
      ALU_GEU:   r = {31'b0, a >= b};
      ALU_SLT:   r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  r = {31'b0, a < b};
      default:   r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU op, operand selects,
// memory/writeback controls and the illegal-instruction flag.
module alu_decoder
  import riscv_defs::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       f7_bit5,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_SUM;
    ctrl.a_sel  = A_RS1;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        ctrl.b_imm     = (opcode == OPC_OP_IMM);
        ctrl.reg_write = 1'b1;
        case (funct3)
          3'b000:  ctrl.alu_op = (opcode == OPC_OP && f7_bit5) ? ALU_SUB : ALU_SUM;
          3'b001:  ctrl.alu_op = ALU_SLL;
          3'b010:  ctrl.alu_op = ALU_SLT;
          3'b011:  ctrl.alu_op = ALU_SLTU;
          3'b100:  ctrl.alu_op = ALU_XOR;
          3'b101:  ctrl.alu_op = f7_bit5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        ctrl.b_imm     = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      OPC_STORE: begin
        ctrl.b_imm     = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OPC_LUI: begin
        ctrl.a_sel     = A_ZERO;
        ctrl.b_imm     = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.a_sel     = A_PC;
        ctrl.b_imm     = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        ctrl.b_imm     = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.is_jal    = 1'b1;
      end
      OPC_JALR: begin
        ctrl.b_imm     = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.is_jalr   = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.is_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: ctrl.alu_op = ALU_EQUAL;
          3'b100:         ctrl.alu_op = ALU_SLT;
          3'b101:         ctrl.alu_op = ALU_GE;
          3'b110:         ctrl.alu_op = ALU_SLTU;
          3'b111:         ctrl.alu_op = ALU_GEU;
          default: begin
            ctrl.is_branch = 1'b0;
            ctrl.illegal   = 1'b1;
          end
        endcase
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: decode, ALU, branch/jump resolution and a one-entry
// EX/MEM output slot with valid/ready handshake and a registered redirect pulse.
module execute_stage
  import riscv_defs::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_VALID_i,
  output logic        IN_READY_o,
  input  logic [6:0]  OPCODE_i,
  input  logic [2:0]  FUNCT3_i,
  input  logic [6:0]  FUNCT7_i,
  input  logic [31:0] PC_i,
  input  logic [31:0] RS1_DATA_i,
  input  logic [31:0] RS2_DATA_i,
  input  logic [31:0] IMM_i,
  input  logic [4:0]  RD_ADDR_i,
  input  logic        FLUSH_i,
  output logic        OUT_VALID_o,
  input  logic        OUT_READY_i,
  output logic [31:0] OUT_RESULT_o,
  output logic [31:0] OUT_STORE_DATA_o,
  output logic [4:0]  OUT_RD_ADDR_o,
  output logic [2:0]  OUT_FUNCT3_o,
  output logic        OUT_REG_WRITE_o,
  output logic        OUT_MEM_READ_o,
  output logic        OUT_MEM_WRITE_o,
  output logic        OUT_ILLEGAL_o,
  output logic        REDIRECT_o,
  output logic [31:0] REDIRECT_PC_o
);

  ctrl_t       ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [31:0] pc_plus_imm;
  logic [31:0] pc_plus_4;
  logic [31:0] next_result;
  logic [31:0] next_target;
  logic        taken;
  logic        do_redirect;
  logic        accept;
  logic        unused_f7;

  // Only funct7[5] distinguishes SUB/SRA; the remaining bits carry no meaning here.
  assign unused_f7 = ^{FUNCT7_i[6], FUNCT7_i[4:0]};

  alu_decoder u_alu_decoder (
    .opcode  (OPCODE_i),
    .funct3  (FUNCT3_i),
    .f7_bit5 (FUNCT7_i[5]),
    .ctrl    (ctrl)
  );

  always_comb begin
    op_a = RS1_DATA_i;
    case (ctrl.a_sel)
      A_PC:    op_a = PC_i;
      A_ZERO:  op_a = 32'h0;
      default: op_a = RS1_DATA_i;
    endcase
  end

  assign op_b       = ctrl.b_imm ? IMM_i : RS2_DATA_i;
  assign alu_result = alu_compute(ctrl.alu_op, op_a, op_b);

  assign pc_plus_imm = PC_i + IMM_i;
  assign pc_plus_4   = PC_i + 32'd4;

  // BEQ and BNE share the EQUAL op; BNE is taken when the equality result is zero.
  assign taken = ctrl.is_branch &
                 ((FUNCT3_i == F3_BNE) ? (alu_result == 32'h0) : alu_result[0]);
  assign do_redirect = taken | ctrl.is_jal | ctrl.is_jalr;
  assign next_target = ctrl.is_jalr ? (alu_result & ~32'h1) : pc_plus_imm;
  assign next_result = (ctrl.is_jal | ctrl.is_jalr) ? pc_plus_4 : alu_result;

  assign IN_READY_o = !OUT_VALID_o | OUT_READY_i | FLUSH_i;
  assign accept     = IN_VALID_i & IN_READY_o & !FLUSH_i;

  // Slot register: flush wins over accept/hold; payload only moves on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_VALID_o      <= 1'b0;
      OUT_RESULT_o     <= 32'h0;
      OUT_STORE_DATA_o <= 32'h0;
      OUT_RD_ADDR_o    <= 5'h0;
      OUT_FUNCT3_o     <= 3'h0;
      OUT_REG_WRITE_o  <= 1'b0;
      OUT_MEM_READ_o   <= 1'b0;
      OUT_MEM_WRITE_o  <= 1'b0;
      OUT_ILLEGAL_o    <= 1'b0;
      REDIRECT_o       <= 1'b0;
      REDIRECT_PC_o    <= RESET_VECTOR;
    end else begin
      REDIRECT_o <= accept & do_redirect;
      if (accept && do_redirect) begin
        REDIRECT_PC_o <= next_target;
      end

      if (FLUSH_i) begin
        OUT_VALID_o <= 1'b0;
      end else if (accept) begin
        OUT_VALID_o <= 1'b1;
      end else if (OUT_READY_i) begin
        OUT_VALID_o <= 1'b0;
      end

      if (accept) begin
        OUT_RESULT_o     <= next_result;
        OUT_STORE_DATA_o <= RS2_DATA_i;
        OUT_RD_ADDR_o    <= RD_ADDR_i;
        OUT_FUNCT3_o     <= FUNCT3_i;
        OUT_REG_WRITE_o  <= ctrl.reg_write & (RD_ADDR_i != 5'd0) & !ctrl.illegal;
        OUT_MEM_READ_o   <= ctrl.mem_read & !ctrl.illegal;
        OUT_MEM_WRITE_o  <= ctrl.mem_write & !ctrl.illegal;
        OUT_ILLEGAL_o    <= ctrl.illegal;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage; expected values are hand-computed
// from RV32I semantics and compared through a single checking task.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd_addr;
  logic [2:0]  out_funct3;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_illegal;
  logic        redirect;
  logic [31:0] redirect_pc;

  int vector_count;
  int miscompare_count;

  execute_stage #(.RESET_VECTOR(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .IN_VALID_i       (in_valid),
    .IN_READY_o       (in_ready),
    .OPCODE_i         (opcode),
    .FUNCT3_i         (funct3),
    .FUNCT7_i         (funct7),
    .PC_i             (pc),
    .RS1_DATA_i       (rs1_data),
    .RS2_DATA_i       (rs2_data),
    .IMM_i            (imm),
    .RD_ADDR_i        (rd_addr),
    .FLUSH_i          (flush),
    .OUT_VALID_o      (out_valid),
    .OUT_READY_i      (out_ready),
    .OUT_RESULT_o     (out_result),
    .OUT_STORE_DATA_o (out_store_data),
    .OUT_RD_ADDR_o    (out_rd_addr),
    .OUT_FUNCT3_o     (out_funct3),
    .OUT_REG_WRITE_o  (out_reg_write),
    .OUT_MEM_READ_o   (out_mem_read),
    .OUT_MEM_WRITE_o  (out_mem_write),
    .OUT_ILLEGAL_o    (out_illegal),
    .REDIRECT_o       (redirect),
    .REDIRECT_PC_o    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one instruction and raises IN_VALID; the caller advances the clock.
  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] pc_v,
                               input logic [31:0] rs1_v, input logic [31:0] rs2_v,
                               input logic [31:0] imm_v, input logic [4:0] rd_v);
    opcode   = opc;
    funct3   = f3;
    funct7   = f7;
    pc       = pc_v;
    rs1_data = rs1_v;
    rs2_data = rs2_v;
    imm      = imm_v;
    rd_addr  = rd_v;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted instruction: drive, clock, drop valid; slot is then observable.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] pc_v, input logic [31:0] rs1_v,
                       input logic [31:0] rs2_v, input logic [31:0] imm_v,
                       input logic [4:0] rd_v);
    applyStimulus(opc, f3, f7, pc_v, rs1_v, rs2_v, imm_v, rd_v);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    vector_count     = 0;
    miscompare_count = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    opcode    = 7'h0;
    funct3    = 3'h0;
    funct7    = 7'h0;
    pc        = 32'h0;
    rs1_data  = 32'h0;
    rs2_data  = 32'h0;
    imm       = 32'h0;
    rd_addr   = 5'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("reset_redirect", {31'b0, redirect}, 32'h0);
    checkOutput("reset_redirect_pc", redirect_pc, 32'h0);
    checkOutput("reset_result", out_result, 32'h0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'h1);

    // SUB x5 = 7 - 5
    issue(7'b0110011, 3'b000, 7'b0100000, 32'h0, 32'd7, 32'd5, 32'h0, 5'd5);
    checkOutput("sub_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("sub_result", out_result, 32'd2);
    checkOutput("sub_reg_write", {31'b0, out_reg_write}, 32'h1);
    checkOutput("sub_rd", {27'b0, out_rd_addr}, 32'd5);
    tick();
    checkOutput("sub_drained", {31'b0, out_valid}, 32'h0);

    // SRAI by 4 of 0x80000000
    issue(7'b0010011, 3'b101, 7'b0100000, 32'h0, 32'h8000_0000, 32'h0, 32'd4, 5'd6);
    checkOutput("srai_result", out_result, 32'hF800_0000);

    // BNE 3 != 4 -> taken to 0x100 - 8
    issue(7'b1100011, 3'b001, 7'h0, 32'h100, 32'd3, 32'd4, 32'hFFFF_FFF8, 5'd0);
    checkOutput("bne_redirect", {31'b0, redirect}, 32'h1);
    checkOutput("bne_target", redirect_pc, 32'h0000_00F8);
    checkOutput("bne_reg_write", {31'b0, out_reg_write}, 32'h0);
    tick();
    checkOutput("bne_pulse_end", {31'b0, redirect}, 32'h0);

    // BEQ 3 == 4 is false -> no redirect, target register holds
    issue(7'b1100011, 3'b000, 7'h0, 32'h100, 32'd3, 32'd4, 32'hFFFF_FFF8, 5'd0);
    checkOutput("beq_redirect", {31'b0, redirect}, 32'h0);
    checkOutput("beq_target_hold", redirect_pc, 32'h0000_00F8);

    // JALR: (0x1003 + 4) & ~1, link 0x44
    issue(7'b1100111, 3'b000, 7'h0, 32'h40, 32'h1003, 32'h0, 32'd4, 5'd1);
    checkOutput("jalr_redirect", {31'b0, redirect}, 32'h1);
    checkOutput("jalr_target", redirect_pc, 32'h0000_1006);
    checkOutput("jalr_link", out_result, 32'h0000_0044);
    checkOutput("jalr_reg_write", {31'b0, out_reg_write}, 32'h1);

    // JAL: target 0x320, link 0x304
    issue(7'b1101111, 3'b000, 7'h0, 32'h300, 32'h0, 32'h0, 32'h20, 5'd1);
    checkOutput("jal_target", redirect_pc, 32'h0000_0320);
    checkOutput("jal_link", out_result, 32'h0000_0304);

    // BLT -1 < 1 taken; BLTU 0xFFFFFFFF < 1 not taken; BGE 5 >= 5 taken
    issue(7'b1100011, 3'b100, 7'h0, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0);
    checkOutput("blt_redirect", {31'b0, redirect}, 32'h1);
    checkOutput("blt_target", redirect_pc, 32'h0000_0510);
    issue(7'b1100011, 3'b110, 7'h0, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0);
    checkOutput("bltu_redirect", {31'b0, redirect}, 32'h0);
    issue(7'b1100011, 3'b101, 7'h0, 32'h600, 32'd5, 32'd5, 32'h8, 5'd0);
    checkOutput("bge_redirect", {31'b0, redirect}, 32'h1);
    checkOutput("bge_target", redirect_pc, 32'h0000_0608);

    // Branch funct3 010 is illegal: no redirect
    issue(7'b1100011, 3'b010, 7'h0, 32'h700, 32'd1, 32'd1, 32'h8, 5'd0);
    checkOutput("br010_illegal", {31'b0, out_illegal}, 32'h1);
    checkOutput("br010_redirect", {31'b0, redirect}, 32'h0);

    // LUI ignores rs1; AUIPC adds PC
    issue(7'b0110111, 3'b000, 7'h0, 32'h0, 32'h0000_FFFF, 32'h0, 32'h1234_5000, 5'd8);
    checkOutput("lui_result", out_result, 32'h1234_5000);
    issue(7'b0010111, 3'b000, 7'h0, 32'h1000, 32'h0, 32'h0, 32'h2000, 5'd8);
    checkOutput("auipc_result", out_result, 32'h0000_3000);

    // SW: address 0x108, store data rs2, no writeback
    issue(7'b0100011, 3'b010, 7'h0, 32'h0, 32'h100, 32'hDEAD_BEEF, 32'd8, 5'd0);
    checkOutput("sw_addr", out_result, 32'h0000_0108);
    checkOutput("sw_data", out_store_data, 32'hDEAD_BEEF);
    checkOutput("sw_ctrl", {28'b0, out_mem_write, out_mem_read, out_reg_write, 1'b0}, 32'h8);
    checkOutput("sw_funct3", {29'b0, out_funct3}, 32'h2);

    // LBU: address 0x200 - 4
    issue(7'b0000011, 3'b100, 7'h0, 32'h0, 32'h200, 32'h0, 32'hFFFF_FFFC, 5'd7);
    checkOutput("lbu_addr", out_result, 32'h0000_01FC);
    checkOutput("lbu_ctrl", {28'b0, out_mem_write, out_mem_read, out_reg_write, 1'b0}, 32'h6);

    // ADD to x0 wraps and is not written back
    issue(7'b0110011, 3'b000, 7'h0, 32'h0, 32'hFFFF_FFFF, 32'd2, 32'h0, 5'd0);
    checkOutput("add_wrap", out_result, 32'h1);
    checkOutput("add_x0_reg_write", {31'b0, out_reg_write}, 32'h0);

    // SLTI / SLTIU with -1 against 0
    issue(7'b0010011, 3'b010, 7'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd9);
    checkOutput("slti_result", out_result, 32'h1);
    issue(7'b0010011, 3'b011, 7'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd9);
    checkOutput("sltiu_result", out_result, 32'h0);
    tick();

    // Backpressure: A accepted, B offered while the slot is stalled for 3 cycles
    out_ready = 1'b0;
    applyStimulus(7'b0110011, 3'b000, 7'h0, 32'h0, 32'd1, 32'd1, 32'h0, 5'd10);
    tick();
    applyStimulus(7'b0110011, 3'b100, 7'h0, 32'h0, 32'h0F0F_0000, 32'h00FF_00FF, 32'h0, 5'd11);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_hold_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("bp_hold_result", out_result, 32'd2);
      checkOutput("bp_hold_rd", {27'b0, out_rd_addr}, 32'd10);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'b0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_second_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("bp_second_rd", {27'b0, out_rd_addr}, 32'd11);
    checkOutput("bp_second_result", out_result, 32'h0FF0_00FF);
    tick();
    checkOutput("bp_no_duplicate", {31'b0, out_valid}, 32'h0);

    // Flush with a full stalled slot and a JAL offered: both discarded
    out_ready = 1'b0;
    issue(7'b0110011, 3'b000, 7'h0, 32'h0, 32'd3, 32'd3, 32'h0, 5'd6);
    applyStimulus(7'b1101111, 3'b000, 7'h0, 32'h200, 32'h0, 32'h0, 32'h10, 5'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("flush_redirect", {31'b0, redirect}, 32'h0);
    out_ready = 1'b1;

    // Unknown opcode 0x7F
    issue(7'h7F, 3'b000, 7'h0, 32'h0, 32'd1, 32'd1, 32'h0, 5'd3);
    checkOutput("illegal_flag", {31'b0, out_illegal}, 32'h1);
    checkOutput("illegal_reg_write", {31'b0, out_reg_write}, 32'h0);
    checkOutput("illegal_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("illegal_redirect", {31'b0, redirect}, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
